// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the display scan-out
// fetch, the drawing-engine writer and the host reader.
//
// Display always wins; writer and reader split the remaining cycles
// round-robin. Read data returns a fixed 2 cycles after the grant for both
// read requesters (1 cycle VRAM latency + 1 output register).
//
// rst is asynchronous and active-low. Its deassertion is expected to be
// synchronous to clk; the grant is gated directly by rst, so the first cycle
// after release already arbitrates.
//
// Optional build: define VRAM_ARB_STATS_EN to add stats_clr and the
// saturating wr_stall_cnt / rd_stall_cnt counters.

module vram_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,

    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_rdata,
    output logic              rd_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              disp_underrun
`ifdef VRAM_ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       wr_stall_cnt,
    output logic [15:0]       rd_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_WR   = 2'd2,
        OWN_RD   = 2'd3
    } owner_e;

    localparam logic RR_WR = 1'b0;
    localparam logic RR_RD = 1'b1;

    owner_e            owner;

    logic              rr_ptr_q;
    logic              rr_ptr_d;
    owner_e            tag_q;
    owner_e            tag_d;
    logic              disp_pend_q;
    logic              disp_pend_d;
    logic              disp_rvalid_q;
    logic              disp_rvalid_d;
    logic [DATA_W-1:0] disp_rdata_q;
    logic [DATA_W-1:0] disp_rdata_d;
    logic              rd_rvalid_q;
    logic              rd_rvalid_d;
    logic [DATA_W-1:0] rd_rdata_q;
    logic [DATA_W-1:0] rd_rdata_d;
    logic              underrun_q;
    logic              underrun_d;

    // Grant decision: display first, then the lone requester, then rr_ptr.
    // Held at NONE while in reset so nothing reaches the VRAM.
    always_comb begin
        owner = OWN_NONE;
        if (!rst) begin
            owner = OWN_NONE;
        end else if (disp_req) begin
            owner = OWN_DISP;
        end else if (wr_valid && rd_valid) begin
            owner = (rr_ptr_q == RR_RD) ? OWN_RD : OWN_WR;
        end else if (wr_valid) begin
            owner = OWN_WR;
        end else if (rd_valid) begin
            owner = OWN_RD;
        end
    end

    // Next state: round-robin pointer, read-return tag and output stage.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        tag_d         = OWN_NONE;
        disp_pend_d   = 1'b0;
        disp_rvalid_d = 1'b0;
        disp_rdata_d  = disp_rdata_q;
        rd_rvalid_d   = 1'b0;
        rd_rdata_d    = rd_rdata_q;
        underrun_d    = underrun_q;

        // Only a served writer/reader moves the pointer; the other side goes next.
        case (owner)
            OWN_WR:  rr_ptr_d = RR_RD;
            OWN_RD:  rr_ptr_d = RR_WR;
            default: rr_ptr_d = rr_ptr_q;
        endcase

        // Writes return nothing, so only read owners are tagged.
        if (owner == OWN_DISP || owner == OWN_RD) begin
            tag_d = owner;
        end
        disp_pend_d = (owner == OWN_DISP);

        // mem_rdata belongs to the grant made one cycle ago, named by tag_q.
        if (tag_q == OWN_DISP) begin
            disp_rvalid_d = 1'b1;
            disp_rdata_d  = mem_rdata;
        end
        if (tag_q == OWN_RD) begin
            rd_rvalid_d = 1'b1;
            rd_rdata_d  = mem_rdata;
        end

        // Safety net: a display read in the return pipe whose tag no longer
        // says DISP would lose its pixel. The single tag stage makes this
        // unreachable; the flag stays up until reset if it ever happens.
        if (disp_req && disp_pend_q && (tag_q != OWN_DISP)) begin
            underrun_d = 1'b1;
        end
    end

    // State register; reset drops any in-flight read return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q      <= RR_WR;
            tag_q         <= OWN_NONE;
            disp_pend_q   <= 1'b0;
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
            rd_rvalid_q   <= 1'b0;
            rd_rdata_q    <= '0;
            underrun_q    <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            tag_q         <= tag_d;
            disp_pend_q   <= disp_pend_d;
            disp_rvalid_q <= disp_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
            rd_rvalid_q   <= rd_rvalid_d;
            rd_rdata_q    <= rd_rdata_d;
            underrun_q    <= underrun_d;
        end
    end

    // Outputs: VRAM port and handshakes follow the current grant directly.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_ready  = 1'b0;
        rd_ready  = 1'b0;
        case (owner)
            OWN_DISP: begin
                mem_en   = 1'b1;
                mem_addr = disp_addr;
            end
            OWN_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                wr_ready  = 1'b1;
            end
            OWN_RD: begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
                rd_ready = 1'b1;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase

        disp_rvalid   = disp_rvalid_q;
        disp_rdata    = disp_rdata_q;
        rd_rvalid     = rd_rvalid_q;
        rd_rdata      = rd_rdata_q;
        disp_underrun = underrun_q;
    end

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] wr_stall_q;
    logic [15:0] wr_stall_d;
    logic [15:0] rd_stall_q;
    logic [15:0] rd_stall_d;

    // Stall counters: count valid-without-ready cycles, saturate, clear wins.
    always_comb begin
        wr_stall_d = wr_stall_q;
        rd_stall_d = rd_stall_q;
        if (stats_clr) begin
            wr_stall_d = '0;
            rd_stall_d = '0;
        end else begin
            if (wr_valid && !wr_ready && (wr_stall_q != 16'hFFFF)) begin
                wr_stall_d = wr_stall_q + 16'd1;
            end
            if (rd_valid && !rd_ready && (rd_stall_q != 16'hFFFF)) begin
                rd_stall_d = rd_stall_q + 16'd1;
            end
        end
    end

    // Stall counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_stall_q <= '0;
            rd_stall_q <= '0;
        end else begin
            wr_stall_q <= wr_stall_d;
            rd_stall_q <= rd_stall_d;
        end
    end

    // Counter outputs.
    always_comb begin
        wr_stall_cnt = wr_stall_q;
        rd_stall_cnt = rd_stall_q;
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a behavioural 1-cycle VRAM.
// Read returns are scoreboarded: expected data and arrival cycle are queued
// when the bench expects a read grant and popped when the return is due.

module tb_vram_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 12;

    logic              clk;
    logic              rst;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_rdata;
    logic              rd_rvalid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              disp_underrun;
`ifdef VRAM_ARB_STATS_EN
    logic              stats_clr;
    logic [15:0]       wr_stall_cnt;
    logic [15:0]       rd_stall_cnt;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t disp_q[$];
    exp_t rd_q[$];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   sampled  = 0;
    logic model_rr = 1'b0;

    logic [DATA_W-1:0] vmem [0:(1<<ADDR_W)-1];

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_rdata   (disp_rdata),
        .disp_rvalid  (disp_rvalid),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rd_rdata     (rd_rdata),
        .rd_rvalid    (rd_rvalid),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .disp_underrun(disp_underrun)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .wr_stall_cnt (wr_stall_cnt),
        .rd_stall_cnt (rd_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port VRAM: write on the edge, read data valid the next cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) vmem[mem_addr] <= mem_wdata;
            else        mem_rdata      <= vmem[mem_addr];
        end
    end

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return a[11:0] ^ {a[16:12], 7'h35};
    endfunction

    // Compare due read returns against the scoreboard; anything undue must be idle.
    task automatic check_returns();
        checks++;
        if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
            if (disp_rvalid !== 1'b1 || disp_rdata !== disp_q[0].data) begin
                failures++;
                $display("FAIL disp_return cyc=%0d got rvalid=%b data=%h want rvalid=1 data=%h",
                         cyc, disp_rvalid, disp_rdata, disp_q[0].data);
            end
            void'(disp_q.pop_front());
        end else if (disp_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL disp_rvalid_unexpected cyc=%0d got rvalid=%b want 0", cyc, disp_rvalid);
        end
        checks++;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            if (rd_rvalid !== 1'b1 || rd_rdata !== rd_q[0].data) begin
                failures++;
                $display("FAIL rd_return cyc=%0d got rvalid=%b data=%h want rvalid=1 data=%h",
                         cyc, rd_rvalid, rd_rdata, rd_q[0].data);
            end
            void'(rd_q.pop_front());
        end else if (rd_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rd_rvalid_unexpected cyc=%0d got rvalid=%b want 0", cyc, rd_rvalid);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_returns();
        sampled = 1;
    endtask

    task automatic next_cycle();
        if (!sampled) sample();
        sampled = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic push_disp(input logic [DATA_W-1:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 2;
        disp_q.push_back(e);
    endtask

    task automatic push_rd(input logic [DATA_W-1:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 2;
        rd_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        disp_req = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
        wr_addr = 17'h1F000; wr_data = 12'h5C3; rd_addr = 17'h00020; disp_addr = 17'h00040;
        next_cycle();
        next_cycle();
        checks++;
        if (mem_en !== 1'b0) begin
            failures++; $display("FAIL reset_mem_en got %b want 0", mem_en);
        end
        checks++;
        if ({wr_ready, rd_ready} !== 2'b00) begin
            failures++; $display("FAIL reset_ready got %b want 00", {wr_ready, rd_ready});
        end
        checks++;
        if ({disp_rvalid, rd_rvalid, disp_underrun, disp_rdata, rd_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_regs got dv=%b rv=%b un=%b dd=%h rd=%h want all 0",
                     disp_rvalid, rd_rvalid, disp_underrun, disp_rdata, rd_rdata);
        end
        rst = 1'b1;
        disp_req = 1'b0;
        sample();
        checks++;
        if ({wr_ready, rd_ready} !== 2'b10) begin
            failures++; $display("FAIL reset_first_grant got wr/rd=%b want 10", {wr_ready, rd_ready});
        end
        model_rr = 1'b1;
        next_cycle();
        wr_valid = 1'b0;
        sample();
        checks++;
        if (rd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_second_grant got rd_ready=%b want 1", rd_ready);
        end
        push_rd(pat(17'h00020));
        model_rr = 1'b0;
        next_cycle();
        rd_valid = 1'b0;
        checks++;
        if (vmem[17'h1F000] !== 12'h5C3) begin
            failures++; $display("FAIL reset_first_write got %h want 5c3", vmem[17'h1F000]);
        end
        repeat (3) next_cycle();
    endtask

    task automatic test_display_priority();
        wr_valid = 1'b1; wr_addr = 17'h1F100; wr_data = 12'h321; rd_valid = 1'b0;
        for (int i = 0; i < 320; i++) begin
            disp_req  = 1'b1;
            disp_addr = i[16:0];
            sample();
            checks++;
            if (wr_ready !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== i[16:0]) begin
                failures++;
                $display("FAIL disp_prio_grant i=%0d got wr_ready=%b en=%b we=%b addr=%h want 0 1 0 %h",
                         i, wr_ready, mem_en, mem_we, mem_addr, i[16:0]);
            end
            push_disp(pat(i[16:0]));
            next_cycle();
        end
        disp_req = 1'b0;
        sample();
        checks++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'h1F100 || mem_wdata !== 12'h321) begin
            failures++;
            $display("FAIL disp_prio_release got wr_ready=%b we=%b addr=%h wdata=%h want 1 1 1f100 321",
                     wr_ready, mem_we, mem_addr, mem_wdata);
        end
        model_rr = 1'b1;
        next_cycle();
        wr_valid = 1'b0;
        repeat (3) next_cycle();
    endtask

    task automatic test_round_robin();
        int  wi, ri, wacc, racc;
        logic exp_wr;
        wi = 0; ri = 0; wacc = 0; racc = 0;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; rd_valid = 1'b1;
            wr_addr  = 17'h01000 + wi[16:0];
            wr_data  = 12'h800 + wi[11:0];
            rd_addr  = 17'h00200 + ri[16:0];
            sample();
            exp_wr = (model_rr == 1'b0);
            checks++;
            if ({wr_ready, rd_ready} !== {exp_wr, !exp_wr}) begin
                failures++;
                $display("FAIL rr_grant i=%0d got wr/rd=%b want %b", i, {wr_ready, rd_ready}, {exp_wr, !exp_wr});
            end
            wacc += int'(wr_ready === 1'b1);
            racc += int'(rd_ready === 1'b1);
            if (exp_wr) begin
                wi++;
            end else begin
                push_rd(pat(17'h00200 + ri[16:0]));
                ri++;
            end
            model_rr = exp_wr;
            next_cycle();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        next_cycle();
        checks++;
        if (wacc != 4 || racc != 4) begin
            failures++; $display("FAIL rr_counts got writes=%0d reads=%0d want 4 4", wacc, racc);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (vmem[17'h01000 + k[16:0]] !== 12'h800 + k[11:0]) begin
                failures++;
                $display("FAIL rr_write_data k=%0d got %h want %h", k, vmem[17'h01000 + k[16:0]], 12'h800 + k[11:0]);
            end
        end
        repeat (2) next_cycle();
    endtask

    task automatic test_read_after_write();
        wr_valid = 1'b1; wr_addr = 17'h00100; wr_data = 12'hABC; rd_valid = 1'b0;
        sample();
        checks++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b1) begin
            failures++; $display("FAIL raw_write got wr_ready=%b we=%b want 1 1", wr_ready, mem_we);
        end
        model_rr = 1'b1;
        next_cycle();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 17'h00100;
        sample();
        checks++;
        if (rd_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h00100) begin
            failures++;
            $display("FAIL raw_read got rd_ready=%b en=%b we=%b addr=%h want 1 1 0 00100",
                     rd_ready, mem_en, mem_we, mem_addr);
        end
        push_rd(12'hABC);
        model_rr = 1'b0;
        next_cycle();
        rd_valid = 1'b0;
        repeat (3) next_cycle();
    endtask

    task automatic test_back_to_back();
        int rj;
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1; rd_addr = 17'h00300 + i[16:0];
            sample();
            checks++;
            if (rd_ready !== 1'b1) begin
                failures++; $display("FAIL b2b_read i=%0d got rd_ready=%b want 1", i, rd_ready);
            end
            push_rd(pat(17'h00300 + i[16:0]));
            next_cycle();
        end
        rj = 0;
        for (int i = 0; i < 8; i++) begin
            rd_valid  = 1'b1;
            rd_addr   = 17'h00380 + rj[16:0];
            disp_req  = (i % 2 == 0);
            disp_addr = 17'h00500 + i[16:0];
            sample();
            checks++;
            if (disp_req) begin
                if (rd_ready !== 1'b0 || mem_addr !== disp_addr) begin
                    failures++;
                    $display("FAIL b2b_mix_disp i=%0d got rd_ready=%b addr=%h want 0 %h", i, rd_ready, mem_addr, disp_addr);
                end
                push_disp(pat(17'h00500 + i[16:0]));
            end else begin
                if (rd_ready !== 1'b1 || mem_addr !== rd_addr) begin
                    failures++;
                    $display("FAIL b2b_mix_rd i=%0d got rd_ready=%b addr=%h want 1 %h", i, rd_ready, mem_addr, rd_addr);
                end
                push_rd(pat(17'h00380 + rj[16:0]));
                rj++;
            end
            next_cycle();
        end
        disp_req = 1'b0; rd_valid = 1'b0;
        model_rr = 1'b0;
        repeat (3) next_cycle();
    endtask

    task automatic test_mid_reset();
        rd_valid = 1'b1; rd_addr = 17'h00600;
        sample();
        checks++;
        if (rd_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_grant0 got rd_ready=%b want 1", rd_ready);
        end
        next_cycle();
        rd_addr = 17'h00601;
        sample();
        checks++;
        if (rd_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_grant1 got rd_ready=%b want 1", rd_ready);
        end
        next_cycle();
        checks++;
        if (rd_rvalid !== 1'b1 || rd_rdata !== pat(17'h00600)) begin
            failures++;
            $display("FAIL midrst_pre got rvalid=%b data=%h want 1 %h", rd_rvalid, rd_rdata, pat(17'h00600));
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({rd_rvalid, rd_rdata, rd_ready, mem_en, disp_rvalid} !== '0) begin
            failures++;
            $display("FAIL midrst_async got rv=%b data=%h rdy=%b en=%b dv=%b want all 0",
                     rd_rvalid, rd_rdata, rd_ready, mem_en, disp_rvalid);
        end
        repeat (3) next_cycle();
        rst = 1'b1; rd_valid = 1'b0;
        model_rr = 1'b0;
        repeat (4) next_cycle();
    endtask

`ifdef VRAM_ARB_STATS_EN
    task automatic test_stats();
        rd_valid = 1'b0; wr_valid = 1'b0; disp_req = 1'b0;
        stats_clr = 1'b1;
        next_cycle();
        stats_clr = 1'b0;
        sample();
        checks++;
        if (wr_stall_cnt !== 16'd0 || rd_stall_cnt !== 16'd0) begin
            failures++; $display("FAIL stats_clear got wr=%h rd=%h want 0 0", wr_stall_cnt, rd_stall_cnt);
        end
        next_cycle();
        wr_valid = 1'b1; wr_addr = 17'h1F200; wr_data = 12'h777;
        disp_req = 1'b1; disp_addr = 17'h00010;
        for (int i = 0; i < 5; i++) begin
            push_disp(pat(17'h00010));
            next_cycle();
        end
        sample();
        checks++;
        if (wr_stall_cnt !== 16'd5) begin
            failures++; $display("FAIL stats_count5 got %h want 0005", wr_stall_cnt);
        end
        for (int i = 0; i < 70000; i++) begin
            push_disp(pat(17'h00010));
            next_cycle();
        end
        sample();
        checks++;
        if (wr_stall_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL stats_saturate got %h want ffff", wr_stall_cnt);
        end
        stats_clr = 1'b1;
        push_disp(pat(17'h00010));
        next_cycle();
        stats_clr = 1'b0; disp_req = 1'b0; wr_valid = 1'b0;
        sample();
        checks++;
        if (wr_stall_cnt !== 16'd0 || rd_stall_cnt !== 16'd0) begin
            failures++; $display("FAIL stats_clr_during_stall got wr=%h rd=%h want 0 0", wr_stall_cnt, rd_stall_cnt);
        end
        repeat (3) next_cycle();
    endtask
`endif

    task automatic test_final();
        repeat (3) next_cycle();
        checks++;
        if (disp_q.size() != 0 || rd_q.size() != 0) begin
            failures++;
            $display("FAIL final_queues got disp=%0d rd=%0d pending want 0 0", disp_q.size(), rd_q.size());
        end
        checks++;
        if (disp_underrun !== 1'b0) begin
            failures++; $display("FAIL final_underrun got %b want 0", disp_underrun);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) vmem[i] = pat(i[16:0]);
        mem_rdata = '0;
        rst = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0;
`ifdef VRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_display_priority();
        test_round_robin();
        test_read_after_write();
        test_back_to_back();
        test_mid_reset();
`ifdef VRAM_ARB_STATS_EN
        test_stats();
`endif
        test_final();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
